// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: owns balance, wrong-PIN counter and inactivity timer,
// and sequences card-in -> PIN -> menu -> execute -> eject.
module atm_session_ctrl #(
  parameter int unsigned BAL_W       = 8,
  parameter int unsigned INIT_BAL    = 100,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [BAL_W-1:0] amount,
  input  logic             unlock,
  output logic [2:0]       state,
  output logic [BAL_W-1:0] bal,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             card_eject
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TmrW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPinWait = 3'd1,
    StMenu    = 3'd2,
    StExec    = 3'd3,
    StEject   = 3'd4,
    StLocked  = 3'd5
  } state_t;

  localparam logic [1:0] OpEnd = 2'b00;
  localparam logic [1:0] OpBal = 2'b01;
  localparam logic [1:0] OpWd  = 2'b10;
  localparam logic [1:0] OpDep = 2'b11;

  localparam logic [2:0] ErrPin   = 3'b001;
  localparam logic [2:0] ErrLock  = 3'b010;
  localparam logic [2:0] ErrFunds = 3'b011;
  localparam logic [2:0] ErrOvf   = 3'b100;
  localparam logic [2:0] ErrTmo   = 3'b101;

  state_t           state_q;
  logic [TryW-1:0]  tries_q;
  logic [TmrW-1:0]  timer_q;
  logic [1:0]       op_q;
  logic [BAL_W-1:0] amt_q;

  logic [TryW-1:0]  tries_inc;
  logic [BAL_W:0]   dep_sum;
  logic             timer_exp;

  assign tries_inc = tries_q + TryW'(1);
  // One extra bit so a deposit that wraps shows up as a carry.
  assign dep_sum   = {1'b0, bal} + {1'b0, amount};
  assign timer_exp = (timer_q == TmrW'(TIMEOUT_CYC - 1));
  assign state     = state_q;

  // Session FSM with registered outputs; busy/locked are set on each transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bal        <= BAL_W'(INIT_BAL);
      tries_q    <= '0;
      timer_q    <= '0;
      op_q       <= OpEnd;
      amt_q      <= '0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 3'b000;
      card_eject <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      card_eject <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (card_in) begin
            state_q <= StPinWait;
            busy    <= 1'b1;
            tries_q <= '0;
            timer_q <= '0;
          end
        end
        StPinWait: begin
          timer_q <= timer_q + TmrW'(1);
          if (!card_in) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (pin_valid) begin
            timer_q <= '0;
            if (pin_ok) begin
              state_q <= StMenu;
              tries_q <= '0;
            end else begin
              tries_q <= tries_inc;
              err     <= 1'b1;
              if (tries_inc == TryW'(MAX_TRIES)) begin
                state_q  <= StLocked;
                busy     <= 1'b0;
                locked   <= 1'b1;
                err_code <= ErrLock;
              end else begin
                err_code <= ErrPin;
              end
            end
          end else if (timer_exp) begin
            state_q    <= StEject;
            err        <= 1'b1;
            err_code   <= ErrTmo;
            card_eject <= 1'b1;
          end
        end
        StMenu: begin
          timer_q <= timer_q + TmrW'(1);
          if (!card_in) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (op_valid) begin
            timer_q <= '0;
            op_q    <= op;
            amt_q   <= amount;
            unique case (op)
              OpBal: state_q <= StExec;
              OpWd: begin
                if (amount <= bal) begin
                  state_q <= StExec;
                end else begin
                  err      <= 1'b1;
                  err_code <= ErrFunds;
                end
              end
              OpDep: begin
                if (!dep_sum[BAL_W]) begin
                  state_q <= StExec;
                end else begin
                  err      <= 1'b1;
                  err_code <= ErrOvf;
                end
              end
              default: begin
                state_q    <= StEject;
                card_eject <= 1'b1;
              end
            endcase
          end else if (timer_exp) begin
            state_q    <= StEject;
            err        <= 1'b1;
            err_code   <= ErrTmo;
            card_eject <= 1'b1;
          end
        end
        StExec: begin
          // Commit always completes; a pulled card only changes where we return to.
          done    <= 1'b1;
          timer_q <= '0;
          if (op_q == OpWd) begin
            bal <= bal - amt_q;
          end else if (op_q == OpDep) begin
            bal <= bal + amt_q;
          end
          if (card_in) begin
            state_q <= StMenu;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StEject: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        StLocked: begin
          if (unlock) begin
            state_q <= StIdle;
            locked  <= 1'b0;
            tries_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule
